uart: RTL and testbench



---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_fifo.sv | 64 ++++++
 rtl/uart.sv | 221 ++++++++++++++++++++++
 tb/tb_uart.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and transmitter state machines.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Circular FIFO with full/empty flags. Pushes while full and pops while empty
// are ignored. A push and a pop in the same clock both happen.
module uart_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [ADDR_W-1:0] r_wptr, r_rptr;
  logic              r_full, r_empty;
  logic              w_push, w_pop;
  logic [ADDR_W-1:0] w_wptr_inc, w_rptr_inc;

  assign w_push     = i_wr && !r_full;
  assign w_pop      = i_rd && !r_empty;
  assign w_wptr_inc = r_wptr + 1'b1;
  assign w_rptr_inc = r_rptr + 1'b1;
  assign o_rdata    = r_mem[r_rptr];
  assign o_full     = r_full;
  assign o_empty    = r_empty;

  // Storage array: written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointer and flag update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          r_wptr  <= w_wptr_inc;
          r_empty <= 1'b0;
          r_full  <= (w_wptr_inc == r_rptr);
        end
        2'b01: begin
          r_rptr  <= w_rptr_inc;
          r_full  <= 1'b0;
          r_empty <= (w_rptr_inc == r_wptr);
        end
        2'b11: begin
          r_wptr <= w_wptr_inc;
          r_rptr <= w_rptr_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart.sv
// Full-duplex UART: baud tick generator, 16x oversampling receiver,
// transmitter, and a FIFO in each direction.
module uart
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_AW = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [10:0]     TIMER_FINAL_VALUE,
  input  logic [DBIT-1:0] w_data,
  input  logic            wr_uart,
  output logic            tx_full,
  output logic            tx,
  input  logic            rx,
  input  logic            rd_uart,
  output logic [DBIT-1:0] r_data,
  output logic            rx_empty
);

  // Tick counter must also hold the stop period count when SB_TICK > 16.
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  // ---------------- baud tick ----------------
  logic [10:0] r_baud_cnt;
  logic        w_tick;
  // ">=" keeps the counter from running away when the divisor is lowered.
  assign w_tick = (r_baud_cnt >= TIMER_FINAL_VALUE);

  // Free-running divisor counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_baud_cnt <= '0;
    else       r_baud_cnt <= w_tick ? 11'd0 : r_baud_cnt + 11'd1;
  end

  // ---------------- rx synchronizer ----------------
  logic [1:0] r_rx_sync;
  logic       w_rx;
  assign w_rx = r_rx_sync[1];

  // Two-flop synchronizer, idles high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rx_sync <= 2'b11;
    else       r_rx_sync <= {r_rx_sync[0], rx};
  end

  // ---------------- receiver ----------------
  uart_state_t     r_rx_st, w_rx_st_nx;
  logic [SW-1:0]   r_rx_s, w_rx_s_nx;
  logic [NW-1:0]   r_rx_n, w_rx_n_nx;
  logic [DBIT-1:0] r_rx_b, w_rx_b_nx;
  logic            w_rx_done;

  // Receiver state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_st <= ST_IDLE;
      r_rx_s  <= '0;
      r_rx_n  <= '0;
      r_rx_b  <= '0;
    end else begin
      r_rx_st <= w_rx_st_nx;
      r_rx_s  <= w_rx_s_nx;
      r_rx_n  <= w_rx_n_nx;
      r_rx_b  <= w_rx_b_nx;
    end
  end

  // Receiver next state: find start midpoint, then sample every 16 ticks.
  always_comb begin
    w_rx_st_nx = r_rx_st;
    w_rx_s_nx  = r_rx_s;
    w_rx_n_nx  = r_rx_n;
    w_rx_b_nx  = r_rx_b;
    w_rx_done  = 1'b0;
    unique case (r_rx_st)
      ST_IDLE:
        if (!w_rx) begin
          w_rx_st_nx = ST_START;
          w_rx_s_nx  = '0;
        end
      ST_START:
        if (w_tick) begin
          if (r_rx_s == SW'(7)) begin
            w_rx_st_nx = ST_DATA;
            w_rx_s_nx  = '0;
            w_rx_n_nx  = '0;
          end else w_rx_s_nx = r_rx_s + 1'b1;
        end
      ST_DATA:
        if (w_tick) begin
          if (r_rx_s == SW'(15)) begin
            w_rx_b_nx = {w_rx, r_rx_b[DBIT-1:1]};
            w_rx_s_nx = '0;
            if (r_rx_n == NW'(DBIT-1)) w_rx_st_nx = ST_STOP;
            else                       w_rx_n_nx  = r_rx_n + 1'b1;
          end else w_rx_s_nx = r_rx_s + 1'b1;
        end
      ST_STOP:
        if (w_tick) begin
          if (r_rx_s == SW'(SB_TICK-1)) begin
            w_rx_st_nx = ST_IDLE;
            w_rx_done  = 1'b1;
          end else w_rx_s_nx = r_rx_s + 1'b1;
        end
      default: w_rx_st_nx = ST_IDLE;
    endcase
  end

  // ---------------- rx fifo / read port ----------------
  logic [DBIT-1:0] w_rx_head;
  logic            w_rx_pop;
  assign w_rx_pop = rd_uart && !rx_empty;

  uart_fifo #(.DATA_W(DBIT), .ADDR_W(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_wr    (w_rx_done),
    .i_rd    (w_rx_pop),
    .i_wdata (r_rx_b),
    .o_rdata (w_rx_head),
    .o_full  (),
    .o_empty (rx_empty)
  );

  // Read data register: captures the head on an accepted pop, else holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_data <= '0;
    else if (w_rx_pop) r_data <= w_rx_head;
  end

  // ---------------- transmitter ----------------
  uart_state_t     r_tx_st, w_tx_st_nx;
  logic [SW-1:0]   r_tx_s, w_tx_s_nx;
  logic [NW-1:0]   r_tx_n, w_tx_n_nx;
  logic [DBIT-1:0] r_tx_shift, w_tx_shift_nx;
  logic            r_tx, w_tx_nx;
  logic [DBIT-1:0] w_tx_head;
  logic            w_tx_empty, w_tx_pop;

  assign tx = r_tx;

  uart_fifo #(.DATA_W(DBIT), .ADDR_W(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_wr    (wr_uart),
    .i_rd    (w_tx_pop),
    .i_wdata (w_data),
    .o_rdata (w_tx_head),
    .o_full  (tx_full),
    .o_empty (w_tx_empty)
  );

  // Transmitter state registers; tx line is registered, idles high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_st    <= ST_IDLE;
      r_tx_s     <= '0;
      r_tx_n     <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_st    <= w_tx_st_nx;
      r_tx_s     <= w_tx_s_nx;
      r_tx_n     <= w_tx_n_nx;
      r_tx_shift <= w_tx_shift_nx;
      r_tx       <= w_tx_nx;
    end
  end

  // Transmitter next state; line level follows the next state so tx
  // drops on the same edge that pops the FIFO.
  always_comb begin
    w_tx_st_nx    = r_tx_st;
    w_tx_s_nx     = r_tx_s;
    w_tx_n_nx     = r_tx_n;
    w_tx_shift_nx = r_tx_shift;
    w_tx_pop      = 1'b0;
    unique case (r_tx_st)
      ST_IDLE:
        if (!w_tx_empty) begin
          w_tx_shift_nx = w_tx_head;
          w_tx_pop      = 1'b1;
          w_tx_s_nx     = '0;
          w_tx_st_nx    = ST_START;
        end
      ST_START:
        if (w_tick) begin
          if (r_tx_s == SW'(15)) begin
            w_tx_st_nx = ST_DATA;
            w_tx_s_nx  = '0;
            w_tx_n_nx  = '0;
          end else w_tx_s_nx = r_tx_s + 1'b1;
        end
      ST_DATA:
        if (w_tick) begin
          if (r_tx_s == SW'(15)) begin
            w_tx_shift_nx = r_tx_shift >> 1;
            w_tx_s_nx     = '0;
            if (r_tx_n == NW'(DBIT-1)) w_tx_st_nx = ST_STOP;
            else                       w_tx_n_nx  = r_tx_n + 1'b1;
          end else w_tx_s_nx = r_tx_s + 1'b1;
        end
      ST_STOP:
        if (w_tick) begin
          if (r_tx_s == SW'(SB_TICK-1)) w_tx_st_nx = ST_IDLE;
          else                          w_tx_s_nx  = r_tx_s + 1'b1;
        end
      default: w_tx_st_nx = ST_IDLE;
    endcase
    unique case (w_tx_st_nx)
      ST_START: w_tx_nx = 1'b0;
      ST_DATA:  w_tx_nx = w_tx_shift_nx[0];
      default:  w_tx_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart.sv
// Directed bench for the UART: reset values, loopback byte table, frame
// waveform, FIFO overflow in both directions, pop-when-empty, mid-frame reset.
module tb_uart;

  logic        clk = 1'b0;
  logic        rstn;
  logic [10:0] tfv;
  logic [7:0]  w_data;
  logic        wr_uart, rd_uart;
  logic        tx_full, tx, rx_empty;
  logic [7:0]  r_data;
  logic        rx, rx_drv, loop;

  assign rx = loop ? tx : rx_drv;

  uart dut (
    .clk               (clk),
    .rstn              (rstn),
    .TIMER_FINAL_VALUE (tfv),
    .w_data            (w_data),
    .wr_uart           (wr_uart),
    .tx_full           (tx_full),
    .tx                (tx),
    .rx                (rx),
    .rd_uart           (rd_uart),
    .r_data            (r_data),
    .rx_empty          (rx_empty)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic [7:0] tx_byte;
    logic [7:0] exp_rx;
  } lb_vec_t;

  lb_vec_t    vecs [6];
  logic [9:0] frame_exp;
  logic [7:0] got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [10:0] div);
    rstn    = 1'b0;
    wr_uart = 1'b0;
    rd_uart = 1'b0;
    tfv     = div;
    cyc(3);
    chk("rst_tx", tx, 1);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_r_data", r_data, 0);
    rstn = 1'b1;
    cyc(1);
  endtask

  task automatic wr_byte(input logic [7:0] d);
    int t = 0;
    while (tx_full && t < 2000) begin
      cyc(1);
      t++;
    end
    if (t > 0) chk("tx_space", tx_full, 0);
    w_data  = d;
    wr_uart = 1'b1;
    cyc(1);
    wr_uart = 1'b0;
  endtask

  task automatic pop_wait(input string nm, input int lim, output logic [7:0] d);
    int t = 0;
    while (rx_empty && t < lim) begin
      cyc(1);
      t++;
    end
    chk({nm, "_ready"}, rx_empty, 0);
    rd_uart = 1'b1;
    cyc(1);
    rd_uart = 1'b0;
    d = r_data;
  endtask

  initial begin
    rstn = 1'b0; loop = 1'b1; rx_drv = 1'b1;
    wr_uart = 1'b0; rd_uart = 1'b0; w_data = '0; tfv = '0;

    vecs[0] = '{8'hA5, 8'hA5};
    vecs[1] = '{8'h00, 8'h00};
    vecs[2] = '{8'hFF, 8'hFF};
    vecs[3] = '{8'h01, 8'h01};
    vecs[4] = '{8'h80, 8'h80};
    vecs[5] = '{8'h5A, 8'h5A};
    // start(0), 0x5A LSB first, stop(1)
    frame_exp = {1'b1, 8'h5A, 1'b0};

    // Reset and loopback table at one tick per clock
    do_reset(11'd0);
    for (int i = 0; i < 6; i++) begin
      wr_byte(vecs[i].tx_byte);
      pop_wait("lb", 400, got);
      chk("lb_data", got, vecs[i].exp_rx);
      chk("lb_empty_after_pop", rx_empty, 1);
    end

    // Pop while empty leaves r_data alone
    rd_uart = 1'b1;
    cyc(1);
    rd_uart = 1'b0;
    chk("pop_empty_hold", r_data, 8'h5A);
    chk("pop_empty_flag", rx_empty, 1);

    // Frame shape: first and last clock of every 16-clock segment
    do_reset(11'd0);
    loop = 1'b0;
    w_data  = 8'h5A;
    wr_uart = 1'b1;
    cyc(1);
    wr_uart = 1'b0;
    chk("frame_pre", tx, 1);
    for (int c = 1; c <= 160; c++) begin
      cyc(1);
      if (((c - 1) % 16) == 0 || ((c - 1) % 16) == 15)
        chk($sformatf("frame_c%0d", c), tx, frame_exp[(c - 1) / 16]);
    end
    cyc(1);
    chk("frame_idle", tx, 1);

    // Mid-frame reset clears both FIFOs and aborts the frame
    loop = 1'b1;
    wr_byte(8'hC3);
    wr_byte(8'h3C);
    wr_byte(8'h99);
    cyc(200);
    chk("mid_rx_nonempty", rx_empty, 0);
    chk("mid_tx_busy", tx, 0);
    do_reset(11'd0);
    cyc(400);
    chk("mid_no_resume", rx_empty, 1);

    // TX overflow: six back-to-back writes, sixth dropped
    do_reset(11'd0);
    for (int i = 0; i < 6; i++) begin
      w_data  = 8'h10 + 8'(i);
      wr_uart = 1'b1;
      cyc(1);
      if (i == 4) chk("tx_full_set", tx_full, 1);
    end
    wr_uart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pop_wait("txovf", 400, got);
      chk($sformatf("txovf_data%0d", i), got, 8'h10 + 8'(i));
    end
    cyc(500);
    chk("txovf_only5", rx_empty, 1);

    // RX overflow: six frames, no reads, first four kept
    do_reset(11'd0);
    for (int i = 0; i < 6; i++) wr_byte(8'h30 + 8'(i));
    cyc(1300);
    chk("rxovf_nonempty", rx_empty, 0);
    for (int i = 0; i < 4; i++) begin
      pop_wait("rxovf", 10, got);
      chk($sformatf("rxovf_data%0d", i), got, 8'h30 + 8'(i));
    end
    chk("rxovf_dropped", rx_empty, 1);

    // Loopback with a real divisor
    do_reset(11'd10);
    wr_byte(8'hA5);
    cyc(1500);
    chk("slow_not_early", rx_empty, 1);
    pop_wait("slow", 1500, got);
    chk("slow_data", got, 8'hA5);
    chk("slow_empty", rx_empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
